// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Bus widths here are the defaults; the arbiter can be re-parameterised.
package riscv_mem_pkg;

  localparam int DEF_ADR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

  typedef logic [DEF_BE_WIDTH-1:0] be_t;

  // Fetches always read a full word.
  localparam be_t FETCH_BE = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS,
    BUSY_DROP
  } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
// sat tells the arbiter that the fetch port must win the next grant.
module arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  inc,
  input  logic                                  clr,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]     cnt,
  output logic                                  sat
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  assign sat = (cnt == CW'(STARVE_LIMIT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-ported memory,
// one transaction at a time, data first with a starvation guard for fetch.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int          ADR_WIDTH    = DEF_ADR_WIDTH,
  parameter int          DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  // fetch port
  input  logic                    if_req,
  input  logic [ADR_WIDTH-1:0]    if_adr,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  output logic                    if_stall,
  // data port
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  input  logic [ADR_WIDTH-1:0]    ls_adr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    ls_valid,
  output logic                    ls_stall,
  // memory side
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADR_WIDTH-1:0]    mem_adr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_sat;
  logic             grant_ls, grant_if;
  logic             starve_inc, starve_clr;

  assign if_stall = if_req & ~if_valid;
  assign ls_stall = ls_req & ~ls_valid;

  // A request still high in its own valid cycle is treated as the next request.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      IDLE: begin
        grant_ls = ls_req & (~if_req | ~starve_sat);
        grant_if = ~grant_ls & if_req & ~flush;
        if (grant_ls)      state_d = BUSY_LS;
        else if (grant_if) state_d = BUSY_IF;
      end
      BUSY_IF: begin
        if (mem_ack)    state_d = IDLE;
        else if (flush) state_d = BUSY_DROP;
      end
      BUSY_LS, BUSY_DROP: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign starve_inc = grant_ls & if_req;
  assign starve_clr = (grant_ls & ~if_req) | grant_if;

  arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .cnt    (starve_cnt),
    .sat    (starve_sat)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the data registers are reset as well, so nothing downstream ever
  // sees X on the read-data or memory buses coming out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;

      if (grant_ls) begin
        mem_req   <= 1'b1;
        mem_we    <= ls_we;
        mem_be    <= ls_be;
        mem_adr   <= ls_adr;
        mem_wdata <= ls_wdata;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_adr   <= if_adr;
        mem_wdata <= '0;
      end else if (state_q != IDLE && mem_ack) begin
        mem_req <= 1'b0;
      end

      // Acks in IDLE are ignored; a flushed or abandoned fetch never reports.
      if (mem_ack) begin
        unique case (state_q)
          BUSY_IF: begin
            if (if_req && !flush) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
          BUSY_LS: begin
            if (ls_req) begin
              ls_valid <= 1'b1;
              if (!mem_we) ls_rdata <= mem_rdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

  a_if_req_held: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == BUSY_IF && !flush) |-> if_req);

  a_ls_req_held: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == BUSY_LS) |-> ls_req);

  a_valid_onehot: assert property (@(posedge clk) disable iff (!resetn)
    !(if_valid && ls_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-programmable
// memory responder; each scenario task checks its own hand-derived values.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  logic        clk, resetn;
  logic        if_req, flush, if_valid, if_stall;
  logic [31:0] if_adr, if_rdata;
  logic        ls_req, ls_we, ls_valid, ls_stall;
  logic [3:0]  ls_be;
  logic [31:0] ls_adr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int wait_cnt = 0;
  bit acked = 0;

  mem_port_arbiter #(.ADR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(3)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_adr(if_adr), .flush(flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_adr(ls_adr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid), .ls_stall(ls_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_data(input logic [31:0] adr);
    if (adr == 32'h100)       return 32'h0050_0093;
    else if (adr == 32'h2000) return 32'hCAFE_F00D;
    else                      return adr ^ 32'hA5A5_0000;
  endfunction

  // Memory responder: acks mem_lat cycles after mem_req first appears.
  always @(negedge clk) begin
    if (!mem_req) begin
      wait_cnt = 0;
      acked    = 0;
      mem_ack  = 1'b0;
    end else if (!acked && wait_cnt >= mem_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_data(mem_adr);
      acked     = 1;
    end else begin
      mem_ack = 1'b0;
      if (!acked) wait_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0h expected 0", mem_req); end
    checks++; if (if_valid !== 1'b0 || ls_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b%0b expected 00", if_valid, ls_valid); end
    checks++; if (mem_adr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus: got adr %h be %h wd %h expected zeros", mem_adr, mem_be, mem_wdata); end
    checks++; if (if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h expected 0 0", if_rdata, ls_rdata); end
    checks++; if (dut.state_q !== IDLE || dut.starve_cnt !== 2'd0) begin errors++; $display("FAIL rst_state: got st %0d cnt %0d expected 0 0", dut.state_q, dut.starve_cnt); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_fetch_only();
    mem_lat = 1;
    if_req = 1'b1; if_adr = 32'h100;
    #1;
    checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fo_stall_c0: got %0b expected 1", if_stall); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_adr !== 32'h100) begin errors++; $display("FAIL fo_issue: got req %0b adr %h expected 1 100", mem_req, mem_adr); end
    checks++; if (mem_be !== FETCH_BE || mem_we !== 1'b0) begin errors++; $display("FAIL fo_be_we: got be %h we %0b expected f 0", mem_be, mem_we); end
    checks++; if (dut.state_q !== BUSY_IF || if_stall !== 1'b1) begin errors++; $display("FAIL fo_busy: got st %0d stall %0b expected 1 1", dut.state_q, if_stall); end
    step();
    checks++; if (if_valid !== 1'b0 || if_stall !== 1'b1) begin errors++; $display("FAIL fo_c2: got valid %0b stall %0b expected 0 1", if_valid, if_stall); end
    step();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fo_valid: got %0b %h expected 1 00500093", if_valid, if_rdata); end
    checks++; if (if_stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fo_c3: got stall %0b req %0b expected 0 0", if_stall, mem_req); end
    if_req = 1'b0;
    step();
    checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fo_c4: got valid %0b req %0b expected 0 0", if_valid, mem_req); end
  endtask

  task automatic test_simultaneous();
    mem_lat = 1;
    if_req = 1'b1; if_adr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_adr = 32'h2000;
    step();
    checks++; if (dut.state_q !== BUSY_LS || mem_adr !== 32'h2000) begin errors++; $display("FAIL sim_ls_first: got st %0d adr %h expected 2 2000", dut.state_q, mem_adr); end
    checks++; if (dut.starve_cnt !== 2'd1) begin errors++; $display("FAIL sim_cnt1: got %0d expected 1", dut.starve_cnt); end
    checks++; if (ls_stall !== 1'b1 || if_stall !== 1'b1) begin errors++; $display("FAIL sim_stalls: got %0b %0b expected 1 1", ls_stall, if_stall); end
    step();
    step();
    checks++; if (ls_valid !== 1'b1 || ls_rdata !== 32'hCAFE_F00D || if_valid !== 1'b0) begin errors++; $display("FAIL sim_ls_valid: got %0b %h ifv %0b expected 1 cafef00d 0", ls_valid, ls_rdata, if_valid); end
    ls_req = 1'b0;
    step();
    checks++; if (dut.state_q !== BUSY_IF || mem_adr !== 32'h104 || mem_be !== 4'hF) begin errors++; $display("FAIL sim_if_next: got st %0d adr %h be %h expected 1 104 f", dut.state_q, mem_adr, mem_be); end
    checks++; if (dut.starve_cnt !== 2'd0) begin errors++; $display("FAIL sim_cnt0: got %0d expected 0", dut.starve_cnt); end
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hA5A5_0104 || ls_valid !== 1'b0) begin errors++; $display("FAIL sim_if_valid: got %0b %h lsv %0b expected 1 a5a50104 0", if_valid, if_rdata, ls_valid); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    arb_state_t exp_st [5] = '{BUSY_LS, BUSY_LS, BUSY_LS, BUSY_IF, BUSY_LS};
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    mem_lat = 0;
    if_req = 1'b1; if_adr = 32'h108;
    ls_req = 1'b1; ls_we = 1'b0; ls_adr = 32'h2000;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++; if (if_valid && ls_valid) begin errors++; $display("FAIL starve_onehot c%0d: got both valid expected at most one", c); end
      if (c % 2 == 1) begin
        checks++; if (dut.state_q !== exp_st[c/2] || dut.starve_cnt !== exp_cnt[c/2]) begin
          errors++; $display("FAIL starve_grant c%0d: got st %0d cnt %0d expected %0d %0d", c, dut.state_q, dut.starve_cnt, exp_st[c/2], exp_cnt[c/2]);
        end
      end
      if (c == 8) begin
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hA5A5_0108) begin errors++; $display("FAIL starve_if_valid: got %0b %h expected 1 a5a50108", if_valid, if_rdata); end
        if_req = 1'b0;
      end
      if (c == 10) begin
        checks++; if (ls_valid !== 1'b1) begin errors++; $display("FAIL starve_ls_resume: got %0b expected 1", ls_valid); end
        ls_req = 1'b0;
      end
    end
    step();
  endtask

  task automatic test_flush();
    mem_lat = 2;
    if_req = 1'b1; if_adr = 32'h200; flush = 1'b1;
    step();
    checks++; if (mem_req !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL fl_idle_nogrant: got req %0b st %0d expected 0 0", mem_req, dut.state_q); end
    flush = 1'b0;
    step();
    checks++; if (dut.state_q !== BUSY_IF || mem_adr !== 32'h200) begin errors++; $display("FAIL fl_issue: got st %0d adr %h expected 1 200", dut.state_q, mem_adr); end
    step();
    flush = 1'b1; if_adr = 32'h400;
    step();
    flush = 1'b0;
    checks++; if (dut.state_q !== BUSY_DROP || mem_req !== 1'b1 || mem_adr !== 32'h200) begin errors++; $display("FAIL fl_drop: got st %0d req %0b adr %h expected 3 1 200", dut.state_q, mem_req, mem_adr); end
    step();
    checks++; if (if_valid !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL fl_discard: got valid %0b st %0d expected 0 0", if_valid, dut.state_q); end
    step();
    checks++; if (dut.state_q !== BUSY_IF || mem_adr !== 32'h400) begin errors++; $display("FAIL fl_refetch: got st %0d adr %h expected 1 400", dut.state_q, mem_adr); end
    step();
    step();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fl_early_valid: got %0b expected 0", if_valid); end
    step();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hA5A5_0400) begin errors++; $display("FAIL fl_refetch_valid: got %0b %h expected 1 a5a50400", if_valid, if_rdata); end
    if_req = 1'b0;
    // flush landing in the same cycle as the ack
    mem_lat = 1;
    step();
    if_req = 1'b1; if_adr = 32'h500;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (if_valid !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL fl_same_cycle: got valid %0b st %0d expected 0 0", if_valid, dut.state_q); end
    if_req = 1'b0;
    step();
    checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fl_same_after: got valid %0b req %0b expected 0 0", if_valid, mem_req); end
  endtask

  task automatic test_store();
    mem_lat = 1;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3; ls_adr = 32'h3000; ls_wdata = 32'hDEAD_BEEF;
    step();
    checks++; if (mem_we !== 1'b1 || mem_be !== 4'h3) begin errors++; $display("FAIL st_we_be: got %0b %h expected 1 3", mem_we, mem_be); end
    checks++; if (mem_adr !== 32'h3000 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_adr_wd: got %h %h expected 3000 deadbeef", mem_adr, mem_wdata); end
    step();
    step();
    checks++; if (ls_valid !== 1'b1 || ls_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL st_valid: got %0b %h expected 1 cafef00d", ls_valid, ls_rdata); end
    ls_req = 1'b0; ls_we = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    mem_lat = 100;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_adr = 32'h2000;
    if_req = 1'b1; if_adr = 32'h600;
    step();
    checks++; if (dut.state_q !== BUSY_LS || dut.starve_cnt !== 2'd1) begin errors++; $display("FAIL rm_busy: got st %0d cnt %0d expected 2 1", dut.state_q, dut.starve_cnt); end
    step();
    resetn = 1'b0; ls_req = 1'b0; if_req = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL rm_async: got req %0b st %0d expected 0 0", mem_req, dut.state_q); end
    checks++; if (dut.starve_cnt !== 2'd0 || ls_rdata !== 32'h0) begin errors++; $display("FAIL rm_clear: got cnt %0d rdata %h expected 0 0", dut.starve_cnt, ls_rdata); end
    step();
    mem_lat = 1;
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (ls_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rm_quiet c%0d: got lsv %0b ifv %0b req %0b expected 0 0 0", c, ls_valid, if_valid, mem_req); end
    end
  endtask

  initial begin
    resetn = 1'b0; if_req = 1'b0; if_adr = '0; flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_adr = '0; ls_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction fetch unit (fetch port) and the load/store unit (data port).
- One transaction outstanding at a time. Data has priority; a starvation counter guarantees fetch progress.
- Generates fetch/data stall signals and cancels an in-flight fetch on a branch flush.
- Sits between the IFU, the LSU and the memory wrapper.

Parameters:
ADR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
STARVE_LIMIT, 3, max consecutive data grants while fetch is pending before fetch is forced

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
if_req  input  1  fetch request, level, held until if_valid
if_adr  input  ADR_WIDTH  fetch address, stable while if_req
flush  input  1  branch taken; cancels pending/in-flight fetch
if_rdata  output  DATA_WIDTH  fetched instruction, valid with if_valid
if_valid  output  1  one-cycle fetch completion pulse
if_stall  output  1  if_req & ~if_valid (combinational)
ls_req  input  1  data request, level, held until ls_valid
ls_we  input  1  1 = store
ls_be  input  DATA_WIDTH/8  store byte enables
ls_adr  input  ADR_WIDTH  data address
ls_wdata  input  DATA_WIDTH  store data
ls_rdata  output  DATA_WIDTH  load data, valid with ls_valid
ls_valid  output  1  one-cycle data completion pulse (loads and stores)
ls_stall  output  1  ls_req & ~ls_valid (combinational)
mem_req  output  1  memory request, registered
mem_we  output  1  registered write strobe
mem_be  output  DATA_WIDTH/8  registered byte enables (all ones for fetch)
mem_adr  output  ADR_WIDTH  registered address
mem_wdata  output  DATA_WIDTH  registered write data
mem_ack  input  1  one-cycle completion from memory; mem_rdata valid same cycle
mem_rdata  input  DATA_WIDTH  read data

Behaviour:
- Reset (async, resetn=0):
  - State IDLE, starve_cnt=0.
  - mem_req, mem_we, if_valid, ls_valid = 0; mem_be, mem_adr, mem_wdata, if_rdata, ls_rdata = 0.
  - Reset mid-transaction abandons it; the memory wrapper must tolerate a dropped mem_req.
- States: IDLE, BUSY_IF, BUSY_LS, BUSY_DROP.
- IDLE arbitration, evaluated each cycle:
  - Grant LS when ls_req & (~if_req | starve_cnt < STARVE_LIMIT).
  - Otherwise grant IF when if_req & ~flush.
  - On grant, register the mem_* signals; mem_req=1 from the next cycle. Go to BUSY_LS or BUSY_IF.
  - No grant in a cycle where flush=1 and only if_req is present.
- BUSY_x: hold mem_* stable until mem_ack.
  - On mem_ack: mem_req <= 0, register mem_rdata into if_rdata or ls_rdata, pulse if_valid or ls_valid next cycle, return to IDLE.
  - ls_rdata is updated on loads only; stores leave it unchanged.
- Latency: request sampled cycle 0; mem_req high cycle 1; ack earliest cycle 1; valid cycle 2. New grant possible in cycle 2. Peak throughput is one transaction per 2 cycles.
- Flush:
  - BUSY_IF without ack this cycle: go to BUSY_DROP, keep mem_req until ack, discard the data, no if_valid, then IDLE.
  - BUSY_IF with ack in the same cycle: discard, no if_valid, go to IDLE.
  - Flush in BUSY_DROP, BUSY_LS or IDLE with only ls_req present has no effect.
  - Flush never affects the data port.
- Starvation counter:
  - On an LS grant with if_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On an LS grant with if_req=0, or on any IF grant: starve_cnt clears to 0.
- Boundary conditions:
  - mem_ack outside BUSY_* is ignored.
  - Requester deasserting its req while granted is illegal (assertion); the transaction still completes and its valid pulse is dropped.
  - if_valid and ls_valid are never high in the same cycle.

Decomposition:
- Package riscv_mem_pkg holds:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_LS, BUSY_DROP}
  - ADR_WIDTH/DATA_WIDTH defaults
  - be_t typedef
  - FETCH_BE all-ones constant
- Sub-module arb_starve_cnt: saturating counter with inc/clr/sat outputs, parameter STARVE_LIMIT. The FSM and datapath stay in the top module.

Test Plan:
- Fetch only: if_req=1, if_adr=0x100, mem_ack one cycle after mem_req with rdata 0x00500093 -> mem_adr=0x100, mem_be=0xF, if_valid pulse with if_rdata=0x00500093 at cycle 3, if_stall=1 for cycles 0-2.
- Simultaneous requests: if_req and ls_req (load, adr 0x2000) in cycle 0 -> data granted first, fetch granted in the cycle ls_valid pulses, starve_cnt=1 then 0.
- Starvation: ls_req held continuously with back-to-back loads, if_req=1 -> after 3 LS grants the 4th grant goes to IF; then LS resumes.
- Flush in flight: fetch at 0x200 granted, flush=1 one cycle before mem_ack -> state BUSY_DROP, no if_valid, next fetch to 0x400 issues after the ack.
- Store: ls_we=1, ls_be=0x3, ls_adr=0x3000, ls_wdata=0xDEADBEEF -> mem_we=1, mem_be=0x3, ls_valid pulse, ls_rdata unchanged.
- Reset mid-transaction: resetn low during BUSY_LS -> mem_req=0 immediately, no valid after release, starve_cnt=0.
